// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed serial frame transmitter:
// parity modes, FSM state encoding and frame-length arithmetic.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_e;

    // Total ticks for one frame; unknown parity modes count as no parity.
    function automatic int unsigned frame_ticks(
        input int unsigned data_w,
        input int unsigned parity,
        input int unsigned stop_bits,
        input int unsigned ticks_per_bit
    );
        int unsigned par_bits;
        par_bits = ((parity == PAR_EVEN) || (parity == PAR_ODD)) ? 1 : 0;
        return (1 + data_w + par_bits + stop_bits) * ticks_per_bit;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and registered write-ready.
// Write-ready reflects the next count only, so a pop never frees a slot early.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           rd_en,
    output logic [WIDTH-1:0]               rd_data_c,
    output logic                           empty_c,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [$clog2(DEPTH+1)-1:0]     count_nxt_c,
    output logic                           wr_ready
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr_c;
    logic             do_rd_c;

    assign empty_c   = (count == '0);
    assign do_wr_c   = wr_en & wr_ready;
    assign do_rd_c   = rd_en & ~empty_c;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_nxt_c = count;
        case ({do_wr_c, do_rd_c})
            2'b10:   count_nxt_c = count + 1'b1;
            2'b01:   count_nxt_c = count - 1'b1;
            default: count_nxt_c = count;
        endcase
    end

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_wr_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b0;
        end else begin
            if (do_wr_c) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd_c) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_nxt_c;
            wr_ready <= (count_nxt_c != CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Serial frame transmitter fed by a word FIFO; bit timing is taken from
// rising edges of the shared ticker square wave.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned TICKS_PER_BIT = 1
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               ticker,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               wr_valid,
    output logic                               wr_ready,
    output logic                               signal,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W      = $clog2(DATA_W);
    localparam int unsigned TICK_W     = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam bit          HAS_PARITY = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);

    logic              sync_meta;
    logic              sync_q;
    logic              sync_qq;
    logic              tick_c;

    logic              push_c;
    logic              pop_c;
    logic              load_c;
    logic              period_end_c;
    logic              empty_c;
    logic [DATA_W-1:0] head_c;
    logic [CNT_W-1:0]  count_nxt_c;

    uart_state_e       state_q;
    uart_state_e       state_nxt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic              par_q;
    logic              par_nxt;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [IDX_W-1:0]  bit_idx_nxt;
    logic [TICK_W-1:0] bit_tick_cnt_q;
    logic [TICK_W-1:0] bit_tick_cnt_nxt;
    logic              stop_idx_q;
    logic              stop_idx_nxt;
    logic              signal_nxt;
    logic              busy_nxt;

    // Ticker is asynchronous: two flops of synchronisation, then edge detect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_qq   <= 1'b0;
        end else begin
            sync_meta <= ticker;
            sync_q    <= sync_meta;
            sync_qq   <= sync_q;
        end
    end

    assign tick_c       = sync_q & ~sync_qq;
    assign period_end_c = tick_c && (bit_tick_cnt_q == TICK_W'(TICKS_PER_BIT - 1));
    assign push_c       = wr_valid & wr_ready;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clock),
        .rst_n       (reset_n),
        .wr_en       (push_c),
        .wr_data     (wr_data),
        .rd_en       (pop_c),
        .rd_data_c   (head_c),
        .empty_c     (empty_c),
        .count       (fifo_count),
        .count_nxt_c (count_nxt_c),
        .wr_ready    (wr_ready)
    );

    // Next-state and line-level logic for the frame sequencer.
    always_comb begin
        state_nxt        = state_q;
        shift_nxt        = shift_q;
        par_nxt          = par_q;
        bit_idx_nxt      = bit_idx_q;
        bit_tick_cnt_nxt = bit_tick_cnt_q;
        stop_idx_nxt     = stop_idx_q;
        signal_nxt       = signal;
        load_c           = 1'b0;
        pop_c            = 1'b0;

        if (tick_c && (state_q != S_IDLE)) begin
            bit_tick_cnt_nxt = period_end_c ? '0 : bit_tick_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick_c && !empty_c) begin
                    load_c = 1'b1;
                end
            end
            S_START: begin
                if (period_end_c) begin
                    state_nxt   = S_DATA;
                    signal_nxt  = shift_q[0];
                    shift_nxt   = shift_q >> 1;
                    bit_idx_nxt = '0;
                end
            end
            S_DATA: begin
                if (period_end_c) begin
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        if (HAS_PARITY) begin
                            state_nxt  = S_PARITY;
                            signal_nxt = par_q;
                        end else begin
                            state_nxt    = S_STOP;
                            signal_nxt   = 1'b1;
                            stop_idx_nxt = 1'b0;
                        end
                    end else begin
                        signal_nxt  = shift_q[0];
                        shift_nxt   = shift_q >> 1;
                        bit_idx_nxt = bit_idx_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (period_end_c) begin
                    state_nxt    = S_STOP;
                    signal_nxt   = 1'b1;
                    stop_idx_nxt = 1'b0;
                end
            end
            S_STOP: begin
                // The tick closing the last stop bit may open the next frame.
                if (period_end_c) begin
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        if (!empty_c) begin
                            load_c = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        stop_idx_nxt = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                signal_nxt = 1'b1;
            end
        endcase

        if (load_c) begin
            pop_c            = 1'b1;
            state_nxt        = S_START;
            signal_nxt       = 1'b0;
            shift_nxt        = head_c;
            par_nxt          = (PARITY == PAR_ODD) ? ~^head_c : ^head_c;
            bit_tick_cnt_nxt = '0;
        end

        busy_nxt = (state_nxt != S_IDLE) || (count_nxt_c != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            shift_q        <= '0;
            par_q          <= 1'b0;
            bit_idx_q      <= '0;
            bit_tick_cnt_q <= '0;
            stop_idx_q     <= 1'b0;
            signal         <= 1'b1;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            shift_q        <= shift_nxt;
            par_q          <= par_nxt;
            bit_idx_q      <= bit_idx_nxt;
            bit_tick_cnt_q <= bit_tick_cnt_nxt;
            stop_idx_q     <= stop_idx_nxt;
            signal         <= signal_nxt;
            busy           <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: pushed words queue their expected frames; a tick-rate
// line monitor rebuilds each frame and compares it with the model.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PAR   = 2;
    localparam int STOPB = 2;
    localparam int TPB   = 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int FL    = (1 + DW + 1 + STOPB) * TPB;
    localparam int LIMIT = 20000;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          ticker;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          signal;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] sb [$];
    bit            tick_en = 1'b0;
    bit            gap_check = 1'b0;
    bit            in_frame = 1'b0;
    int            mon_idx = 0;
    int            frames_done = 0;
    int            abort_gen = 0;

    always #5 clock = ~clock;

    uart_tx_fifo #(
        .DATA_W        (DW),
        .FIFO_DEPTH    (DEPTH),
        .PARITY        (PAR),
        .STOP_BITS     (STOPB),
        .TICKS_PER_BIT (TPB)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ticker     (ticker),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .signal     (signal),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Line level per tick for one frame: sample k lives in bit k.
    function automatic logic [31:0] exp_frame(input logic [DW-1:0] w);
        logic [31:0] v;
        logic        b;
        int          nb;
        v  = '0;
        nb = 1 + DW + 1 + STOPB;
        for (int i = 0; i < nb; i++) begin
            if (i == 0)            b = 1'b0;
            else if (i <= DW)      b = w[i-1];
            else if (i == DW + 1)  b = (PAR == 2) ? ~^w : ^w;
            else                   b = 1'b1;
            for (int t = 0; t < TPB; t++) v[i*TPB + t] = b;
        end
        return v;
    endfunction

    // Ticker: 16-clock period square wave, frozen while disabled.
    initial begin
        ticker = 1'b0;
        forever begin
            repeat (8) @(negedge clock);
            if (tick_en) ticker = ~ticker;
        end
    end

    // Monitor: one line sample per tick, mid-way between ticker rises.
    initial begin : monitor
        int            seen_abort;
        bit            expect_start;
        logic          s;
        logic [31:0]   got_v;
        logic [DW-1:0] w;
        seen_abort   = 0;
        expect_start = 1'b0;
        got_v        = '0;
        w            = '0;
        forever begin
            @(negedge ticker);
            repeat (2) @(negedge clock);
            s = signal;
            if (abort_gen != seen_abort) begin
                seen_abort   = abort_gen;
                in_frame     = 1'b0;
                expect_start = 1'b0;
                sb.delete();
            end else begin
                if (expect_start) begin
                    check("no_gap", 32'(s), 32'd0);
                    expect_start = 1'b0;
                end
                if (!in_frame) begin
                    if (s == 1'b0) begin
                        if (sb.size() == 0) begin
                            check("unexpected_start", 32'(sb.size()), 32'd1);
                        end else begin
                            w        = sb.pop_front();
                            got_v    = '0;
                            got_v[0] = s;
                            mon_idx  = 1;
                            in_frame = 1'b1;
                        end
                    end
                end else begin
                    got_v[mon_idx] = s;
                    mon_idx++;
                    if (mon_idx == FL) begin
                        check("frame", got_v, exp_frame(w));
                        in_frame = 1'b0;
                        frames_done++;
                        if (gap_check && sb.size() > 0) expect_start = 1'b1;
                    end
                end
            end
        end
    end

    // Called just after a negedge; returns on a negedge with wr_valid low.
    task automatic push_word(input logic [DW-1:0] w);
        int n;
        wr_data  = w;
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("push_accept", 32'(wr_ready), 32'd1);
        if (wr_ready) sb.push_back(w);
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || in_frame || busy) && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("drain_in_time", 32'(n < LIMIT), 32'd1);
    endtask

    initial begin : main
        int idle_bad;
        int n;
        int exp_frames;
        exp_frames = 0;
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;

        repeat (3) @(negedge clock);
        check("rst_signal", 32'(signal), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("wr_ready_after_rst", 32'(wr_ready), 32'd1);

        // Quiet line with ticks and an empty FIFO.
        tick_en  = 1'b1;
        idle_bad = 0;
        repeat (20) begin
            @(negedge ticker);
            repeat (2) @(negedge clock);
            if (signal !== 1'b1 || busy !== 1'b0 || fifo_count !== '0) idle_bad++;
        end
        check("idle_quiet", 32'(idle_bad), 32'd0);

        // Single word: count and busy around the frame boundaries.
        @(negedge clock);
        push_word(8'd3);
        exp_frames++;
        check("count_after_push", 32'(fifo_count), 32'd1);
        check("busy_after_push", 32'(busy), 32'd1);
        n = 0;
        while (!in_frame && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("frame_started", 32'(in_frame), 32'd1);
        check("count_at_start", 32'(fifo_count), 32'd0);
        n = 0;
        while (frames_done < exp_frames && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("frame_done", 32'(frames_done), 32'(exp_frames));
        check("busy_in_stop", 32'(busy), 32'd1);
        repeat (16) @(negedge clock);
        check("busy_after_stop", 32'(busy), 32'd0);
        check("line_idle", 32'(signal), 32'd1);

        // Back-to-back words must share no idle bit.
        gap_check = 1'b1;
        push_word(8'd45);
        push_word(8'd67);
        exp_frames += 2;
        wait_drain();
        gap_check = 1'b0;

        // Random words with random spacing.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 300)) @(negedge clock);
            push_word(DW'($urandom));
            exp_frames++;
        end
        wait_drain();

        // Fill the FIFO with ticks frozen, then overflow by one.
        tick_en = 1'b0;
        repeat (20) @(negedge clock);
        gap_check = 1'b1;
        push_word(8'd3);
        push_word(8'd45);
        push_word(8'd9);
        push_word(8'd67);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        wr_data  = 8'd101;
        wr_valid = 1'b1;
        repeat (5) @(negedge clock);
        check("full_holds_count", 32'(fifo_count), 32'(DEPTH));
        tick_en = 1'b1;
        push_word(8'd101);
        check("fifth_after_pop", 32'(fifo_count), 32'(DEPTH));
        exp_frames += 5;
        wait_drain();
        gap_check = 1'b0;
        check("frames_total", 32'(frames_done), 32'(exp_frames));

        // Reset during data bit 3 aborts the frame at once.
        push_word(8'd3);
        n = 0;
        while (!(in_frame && mon_idx >= 3 * TPB + TPB + 1) && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("reached_bit3", 32'(in_frame), 32'd1);
        reset_n = 1'b0;
        abort_gen++;
        #1;
        check("abort_signal", 32'(signal), 32'd1);
        check("abort_count", 32'(fifo_count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        push_word(8'd101);
        exp_frames++;
        wait_drain();
        check("frames_final", 32'(frames_done), 32'(exp_frames));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised serial frame transmitter, successor to the single-byte transmitter.
- Accepts parallel words through a valid/ready handshake into an internal FIFO.
- Serialises each word onto `signal` as start bit, LSB-first data, optional parity, then 1 or 2 stop bits.
- Bit timing comes from the shared `ticker` baud square wave.
- Feeds the command extractor and other serial consumers on the same board.

Parameters:
- DATA_W, 8, data bits per frame (5..16).
- FIFO_DEPTH, 4, words buffered; power of two, >=2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.
- TICKS_PER_BIT, 1, `ticker` rising edges per serial bit (>=1).

Ports:
- clock, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- ticker, in, 1, baud square wave, asynchronous to `clock` phase.
- wr_data, in, DATA_W, word to transmit.
- wr_valid, in, 1, wr_data valid.
- wr_ready, out, 1, FIFO can accept a word.
- signal, out, 1, serial line; idles high.
- busy, out, 1, frame in progress or FIFO non-empty.
- fifo_count, out, $clog2(FIFO_DEPTH+1), words held.

Behaviour:
- Reset (async, reset_n=0):
  - signal=1, wr_ready=0 while asserted, then 1 on the first clock after release.
  - busy=0, fifo_count=0.
  - FSM goes to IDLE and FIFO pointers clear.
  - Assertion mid-frame aborts the frame immediately; no partial stop bit is sent.
- Tick generation:
  - `ticker` passes through a 2-flop synchroniser; `tick` = sync_q & ~sync_qq.
  - `tick` is a one-clock pulse, 3 clocks after the ticker rising edge.
  - A bit period is TICKS_PER_BIT ticks, counted by bit_tick_cnt.
- Write side:
  - Push when wr_valid & wr_ready on a rising clock.
  - wr_ready = ~full, registered from the current count; no bypass.
  - When full, a same-cycle pop does not admit a push.
  - wr_data is sampled only on a push.
- FSM states and transitions:
  - IDLE: signal=1. On `tick` with FIFO non-empty, pop the head into shift_reg, go to START; signal=0 on that same clock edge.
  - START: after TICKS_PER_BIT ticks go to DATA; signal=shift_reg[0]; bit_idx=0.
  - DATA: each bit period shift right, bit_idx++. After bit DATA_W-1 go to PARITY if PARITY!=0, else STOP.
  - PARITY: drive ^data (even) or ~^data (odd), computed at pop time.
  - STOP: signal=1 for STOP_BITS bit periods. Then return to IDLE; a next frame may start on the very next `tick`, so back-to-back frames have no extra idle bit.
- Frame length in ticks: (1 + DATA_W + (PARITY!=0) + STOP_BITS) * TICKS_PER_BIT.
- fifo_count:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- busy = (state!=IDLE) | (fifo_count!=0).
- Ticks arriving while the FIFO is empty in IDLE are ignored; signal stays 1.
- Illegal PARITY values (3) behave as none.

Decomposition:
- Package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - FSM state enum (IDLE, START, DATA, PARITY, STOP), 3-bit;
  - the frame-length function.
- Sub-module sync_fifo (params WIDTH, DEPTH) holds storage, pointers, count, full and empty; the top holds the synchroniser, FSM and shift register.

Test Plan:
- Defaults; push 3 once → after a tick, signal carries 0,1,1,0,0,0,0,0,0,1 over 10 bit periods; busy falls after the stop bit; fifo_count 1→0 at frame start.
- PARITY=1; push 45 then 67 back-to-back → frames 0,1,0,1,1,0,1,0,0,P=0,1 then 0,1,1,0,0,0,0,1,0,P=1,1, with no idle gap between them.
- PARITY=2, STOP_BITS=2, TICKS_PER_BIT=2; push 9 → parity bit 1; each bit lasts 2 tick periods; 12 bits total (24 ticks); the line is high for 4 ticks at the end.
- FIFO_DEPTH=4; hold wr_valid with 5 words (3,45,9,67,101) before the first tick → wr_ready drops after 4 pushes; the 5th is accepted only after the first pop; all 5 are transmitted in order.
- Assert reset_n=0 during bit 3 of a frame → signal=1 within the same time step; fifo_count=0; after release a new push of 101 produces a clean frame 0,1,0,1,0,0,1,1,0,1.
- No writes, ticker running for 20 periods → signal stays 1, busy=0, fifo_count=0.
